// File: rtl/key_param_ctrl_pkg.sv
// Shared definitions for the key-driven pipeline configuration block and the
// pipeline's threshold stage: mode encodings, key indices, threshold limits.
package key_param_ctrl_pkg;

   // Processing modes of the edge-detection pipeline
   typedef enum logic [1:0] {
      MODE_GRAY  = 2'd0,
      MODE_SOBEL = 2'd1,
      MODE_BIN   = 2'd2
   } mode_e;

   // Bit positions of the debounced key pulses
   localparam int KEY_MODE = 0;
   localparam int KEY_UP   = 1;
   localparam int KEY_DN   = 2;
   localparam int KEY_RST  = 3;

   // Binarisation threshold defaults, shared with the threshold stage
   localparam int TH_DEF  = 100;
   localparam int TH_STEP = 5;
   localparam int TH_MIN  = 10;
   localparam int TH_MAX  = 250;

   // The single key event acted upon in a cycle after priority resolution
   typedef enum logic [2:0] {
      EVT_NONE,
      EVT_RST,
      EVT_MODE,
      EVT_UP,
      EVT_DN
   } key_evt_e;

endpackage

// File: rtl/key_param_ctrl.sv
// Turns debounced key pulses into the pipeline's run-time mode and threshold.
// Keys edit shadow registers at once; the shadow is copied to the active
// outputs only on frame_start, so a frame never sees mixed settings.
module key_param_ctrl #(
   parameter int KEY_W    = 4,
   parameter int TH_W     = 8,
   parameter int TH_DEF   = key_param_ctrl_pkg::TH_DEF,
   parameter int TH_STEP  = key_param_ctrl_pkg::TH_STEP,
   parameter int TH_MIN   = key_param_ctrl_pkg::TH_MIN,
   parameter int TH_MAX   = key_param_ctrl_pkg::TH_MAX,
   parameter int MODE_NUM = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [KEY_W-1:0] key_vld,
   input  logic            frame_start,
   output logic [1:0]      mode,
   output logic [TH_W-1:0] thresh,
   output logic            cfg_updt,
   output logic            pend
);
   import key_param_ctrl_pkg::*;

   // Threshold constants at the widths the arithmetic uses; the extra bit
   // lets the up-step sum exceed TH_MAX without wrapping.
   localparam logic [TH_W:0]   TH_STEP_X = (TH_W+1)'(TH_STEP);
   localparam logic [TH_W:0]   TH_MIN_X  = (TH_W+1)'(TH_MIN);
   localparam logic [TH_W:0]   TH_MAX_X  = (TH_W+1)'(TH_MAX);
   localparam logic [TH_W-1:0] TH_DEF_V  = TH_W'(TH_DEF);
   localparam logic [TH_W-1:0] TH_STEP_V = TH_W'(TH_STEP);
   localparam logic [TH_W-1:0] TH_MIN_V  = TH_W'(TH_MIN);
   localparam logic [TH_W-1:0] TH_MAX_V  = TH_W'(TH_MAX);
   localparam logic [1:0]      MODE_LAST = 2'(MODE_NUM - 1);

   logic [1:0]      sh_mode, sh_mode_n, mode_n, mode_inc;
   logic [TH_W-1:0] sh_th, sh_th_n, thresh_n, th_up, th_dn;
   logic [TH_W:0]   th_up_sum;
   logic            commit;
   key_evt_e        evt;

   // Pick one key event per cycle: restore > mode > up > down
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      evt = EVT_NONE;
      if (key_vld[KEY_RST])       evt = EVT_RST;
      else if (key_vld[KEY_MODE]) evt = EVT_MODE;
      else if (key_vld[KEY_UP])   evt = EVT_UP;
      else if (key_vld[KEY_DN])   evt = EVT_DN;
   end

   // Candidate shadow values: saturating threshold steps and wrapping mode
   always_comb begin
      th_up_sum = {1'b0, sh_th} + TH_STEP_X;
      th_up     = (th_up_sum > TH_MAX_X) ? TH_MAX_V : th_up_sum[TH_W-1:0];
      th_dn     = ({1'b0, sh_th} < (TH_MIN_X + TH_STEP_X)) ? TH_MIN_V : (sh_th - TH_STEP_V);
      mode_inc  = (sh_mode >= MODE_LAST) ? 2'(MODE_GRAY) : (sh_mode + 2'd1);
   end

   // Next shadow and active values; commit copies the pre-edge shadow
   always_comb begin
      sh_mode_n = sh_mode;
      sh_th_n   = sh_th;
      case (evt)
         EVT_RST: begin
            sh_mode_n = 2'(MODE_GRAY);
            sh_th_n   = TH_DEF_V;
         end
         EVT_MODE: sh_mode_n = mode_inc;
         EVT_UP:   sh_th_n   = th_up;
         EVT_DN:   sh_th_n   = th_dn;
         default: ;
      endcase
      commit   = frame_start & pend;
      mode_n   = commit ? sh_mode : mode;
      thresh_n = commit ? sh_th   : thresh;
   end

   // Shadow, active, pending flag and update pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         sh_mode  <= 2'(MODE_GRAY);
         sh_th    <= TH_DEF_V;
         mode     <= 2'(MODE_GRAY);
         thresh   <= TH_DEF_V;
         pend     <= 1'b0;
         cfg_updt <= 1'b0;
      end else begin
         sh_mode  <= sh_mode_n;
         sh_th    <= sh_th_n;
         mode     <= mode_n;
         thresh   <= thresh_n;
         pend     <= (sh_mode_n != mode_n) || (sh_th_n != thresh_n);
         cfg_updt <= commit;
      end
   end

endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl: key editing, saturation, priority,
// frame-boundary commit and asynchronous reset.
module tb_key_param_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key_vld;
   logic       frame_start;
   logic [1:0] mode;
   logic [7:0] thresh;
   logic       cfg_updt;
   logic       pend;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   key_param_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_vld     (key_vld),
      .frame_start (frame_start),
      .mode        (mode),
      .thresh      (thresh),
      .cfg_updt    (cfg_updt),
      .pend        (pend)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] m, input logic [7:0] t,
                            input logic c, input logic p);
      check({tag, "_mode"},     {30'd0, mode},   {30'd0, m});
      check({tag, "_thresh"},   {24'd0, thresh}, {24'd0, t});
      check({tag, "_cfg_updt"}, {31'd0, cfg_updt}, {31'd0, c});
      check({tag, "_pend"},     {31'd0, pend},   {31'd0, p});
   endtask

   // One clock edge with the given inputs; outputs are stable 1 ns after it
   task automatic step(input logic [3:0] k, input logic fs);
      @(negedge clk);
      key_vld     = k;
      frame_start = fs;
      @(posedge clk);
      #1;
      key_vld     = 4'd0;
      frame_start = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      key_vld     = 4'd0;
      frame_start = 1'b0;
      #12;
      check_all("reset", 2'd0, 8'd100, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frames with no keys never commit
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b1);
         check_all("idle_frame", 2'd0, 8'd100, 1'b0, 1'b0);
      end

      // Two up-steps then commit
      step(4'b0010, 1'b0);
      check_all("up1", 2'd0, 8'd100, 1'b0, 1'b1);
      step(4'b0010, 1'b0);
      check_all("up2", 2'd0, 8'd100, 1'b0, 1'b1);
      step(4'b0000, 1'b1);
      check_all("commit110", 2'd0, 8'd110, 1'b1, 1'b0);
      step(4'b0000, 1'b0);
      check_all("cfg_one_cycle", 2'd0, 8'd110, 1'b0, 1'b0);

      // Saturate upward at 250
      for (int i = 0; i < 40; i++) step(4'b0010, 1'b0);
      check_all("up_sat_pend", 2'd0, 8'd110, 1'b0, 1'b1);
      step(4'b0000, 1'b1);
      check_all("commit250", 2'd0, 8'd250, 1'b1, 1'b0);
      step(4'b0010, 1'b0);
      check_all("up_at_max", 2'd0, 8'd250, 1'b0, 1'b0);

      // Saturate downward at 10
      for (int i = 0; i < 60; i++) step(4'b0100, 1'b0);
      step(4'b0000, 1'b1);
      check_all("commit10", 2'd0, 8'd10, 1'b1, 1'b0);
      step(4'b0100, 1'b0);
      check_all("dn_at_min", 2'd0, 8'd10, 1'b0, 1'b0);

      // Mode wraps after three presses, back to the active value
      step(4'b0001, 1'b0);
      check_all("mode1_pend", 2'd0, 8'd10, 1'b0, 1'b1);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      check_all("mode_wrap", 2'd0, 8'd10, 1'b0, 1'b0);
      step(4'b0000, 1'b1);
      check_all("no_commit_wrap", 2'd0, 8'd10, 1'b0, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b1);
      check_all("commit_mode2", 2'd2, 8'd10, 1'b1, 1'b0);

      // Restore defaults and commit
      step(4'b1000, 1'b0);
      check_all("restore_pend", 2'd2, 8'd10, 1'b0, 1'b1);
      step(4'b0000, 1'b1);
      check_all("commit_default", 2'd0, 8'd100, 1'b1, 1'b0);

      // Restore wins over mode and up; already at defaults so nothing pending
      step(4'b1011, 1'b0);
      check_all("prio_rst", 2'd0, 8'd100, 1'b0, 1'b0);
      step(4'b0000, 1'b1);
      check_all("prio_rst_frame", 2'd0, 8'd100, 1'b0, 1'b0);

      // Key together with frame_start while nothing pending
      step(4'b0010, 1'b1);
      check_all("key_with_frame", 2'd0, 8'd100, 1'b0, 1'b1);
      step(4'b0000, 1'b1);
      check_all("commit105", 2'd0, 8'd105, 1'b1, 1'b0);

      // Mode beats down; up beats down
      step(4'b0101, 1'b0);
      step(4'b0110, 1'b0);
      step(4'b0000, 1'b1);
      check_all("prio_mode_up", 2'd1, 8'd110, 1'b1, 1'b0);

      // Commit uses pre-edge shadow while the same-edge key stays pending
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b1);
      check_all("commit_and_key", 2'd1, 8'd115, 1'b1, 1'b1);
      step(4'b0100, 1'b0);
      check_all("step_back_clears", 2'd1, 8'd115, 1'b0, 1'b0);

      // Non-default active values plus a pending change, then async reset
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b1);
      check_all("commit_mode2b", 2'd2, 8'd115, 1'b1, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b1);
      check_all("commit_mode0", 2'd0, 8'd115, 1'b1, 1'b0);
      step(4'b0001, 1'b0);
      check_all("mode1_pending", 2'd0, 8'd115, 1'b0, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 2'd0, 8'd100, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0000, 1'b1);
      check_all("frame_after_reset", 2'd0, 8'd100, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/key_param_ctrl.md
# key_param_ctrl

Consumes the one-cycle debounced key pulses produced by the key debounce stage and turns them into the run-time configuration of the edge-detection pipeline: processing mode and binarisation threshold. Key events update shadow registers immediately. The shadow values are committed to the active outputs only at a frame boundary, so a frame is never processed with mixed settings. The block sits between the key debounce stage and the image pipeline's control inputs.

## Interface
- KEY_W, 4, number of key pulse inputs (bits 0..3 used; extra bits ignored)
- TH_W, 8, threshold width
- TH_DEF, 100, threshold reset/default value
- TH_STEP, 5, threshold increment/decrement per key event
- TH_MIN, 10, lower threshold bound
- TH_MAX, 250, upper threshold bound
- MODE_NUM, 3, number of valid modes (0..MODE_NUM-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key_vld  in  KEY_W  debounced key events, one-cycle pulse per press
- frame_start  in  1  one-cycle pulse at start of each frame (vsync-derived)
- mode  out  2  active processing mode
- thresh  out  TH_W  active threshold
- cfg_updt  out  1  one-cycle pulse: active configuration changed
- pend  out  1  shadow differs from active; a commit is awaiting frame_start

## Operation
- Key map:
  - key_vld[0]: mode cycle; MODE_NUM-1 wraps to 0.
  - key_vld[1]: threshold +TH_STEP, saturating at TH_MAX.
  - key_vld[2]: threshold -TH_STEP, saturating at TH_MIN.
  - key_vld[3]: restore defaults (mode 0, TH_DEF).
- Multiple bits set in one cycle: only one event is processed, chosen by priority [3] > [0] > [1] > [2]. The others are dropped.
- Saturation arithmetic uses TH_W+1 bits:
  - Up: sh_th + TH_STEP > TH_MAX gives TH_MAX.
  - Down: sh_th < TH_MIN + TH_STEP gives TH_MIN.
- Shadow registers sh_mode and sh_th are updated on the clock edge where the event is present.
- pend is 1 whenever the shadow registers differ from the active registers.
  - An event that leaves the shadow value equal to the active value does not set pend.
  - Example: up-step while saturated.
  - Example: reset while already at defaults.
  - An event that moves the shadow back to equal the active value clears pend.
- Commit happens on the edge where frame_start=1 and pend=1 (pre-edge value):
  - mode <= sh_mode and thresh <= sh_th.
  - cfg_updt is high for exactly the following cycle.
  - frame_start with pend=0 does nothing.

## Timing
- Reset values: mode=0, thresh=TH_DEF, sh_mode=0, sh_th=TH_DEF, pend=0, cfg_updt=0.
- Key event to shadow: 1 edge. pend is valid the cycle after the event.
- Commit: active outputs change on the frame_start edge. cfg_updt is asserted in the cycle after that edge (registered) and is never longer than 1 cycle.
- key_vld and frame_start in the same cycle:
  - The commit uses the pre-edge shadow.
  - The key event updates the shadow on the same edge.
  - pend then reflects the new shadow versus the newly committed active values.
- Back-to-back key pulses on consecutive cycles are each processed. No event is lost unless events collide in the same cycle.
- Reset mid-frame with pend=1 discards pending changes. Outputs return to defaults asynchronously.
- Outputs are driven only by registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - Mode encodings: MODE_GRAY=0, MODE_SOBEL=1, MODE_BIN=2.
  - Key index constants: KEY_MODE=0, KEY_UP=1, KEY_DN=2, KEY_RST=3.
  - TH_DEF, TH_STEP, TH_MIN, TH_MAX defaults, shared with the pipeline's threshold stage.
- Single module with no sub-module.
  - Priority select, saturating step and compare logic are local combinational logic.
  - Shadow, active, pend and cfg_updt are registers.

## Test plan
- Reset, 3 frame_start pulses, no keys: mode=0, thresh=100, pend=0, cfg_updt never high.
- key[1] ×2, then frame_start: pend=1 after the first key; sh_th=110; on the frame_start edge thresh=110; cfg_updt one cycle; pend=0.
- key[1] ×40 then commit: thresh=250 (saturated). One further key[1] leaves pend=0. key[2] ×60 then commit: thresh=10.
- key[0] ×3 then commit: mode=0, pend=0 after the third press, no cfg_updt. key[0] ×2 then commit: mode=2.
- key_vld=4'b1011 (default state, no pend), then frame_start: key[3] wins; shadow equals defaults; pend=0. Then key[1] in the same cycle as frame_start: no commit on that edge, pend=1, commit on the next frame_start gives thresh=105.
- Mode set to 1 with pend=1, rst_n pulsed low mid-frame: outputs return to defaults immediately; the next frame_start produces no cfg_updt.
